// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: blank pattern,
// segment bit positions and the counter width helper.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Segment vector is packed {a,b,c,d,e,f,g}, so 'a' is the MSB.
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex-to-seven-segment decoder, active-high segments {a,b,c,d,e,f,g}.
module seven_seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    // Hex digit lookup.
    always_comb begin
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode display scanner with anti-ghost guard, leading-zero
// blanking and a frame-synchronous double buffer for the displayed value.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int GUARD_CYCLES     = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_leading,
    input  logic                    enable,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              segments
);

    localparam int SW = cnt_width(REFRESH_DIV);
    localparam int DW = cnt_width(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int DN = 2 ** DW;

    localparam logic [SW-1:0] SLOT_LAST   = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] GUARD_END   = SW'(GUARD_CYCLES);
    localparam logic [DW-1:0] DIGIT_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic          ANODE_ON    = (ANODE_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [SW-1:0]         slot_q,       slot_d;
    logic [DW-1:0]         digit_q,      digit_d;
    logic [VW-1:0]         shown_q,      shown_d;
    logic [VW-1:0]         pending_q,    pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  load_ack_q,   load_ack_d;
    logic [NUM_DIGITS-1:0] anodes_q,     anodes_d;
    seg_t                  segments_q,   segments_d;

    logic                  slot_tc_s;
    logic                  frame_end_s;
    logic [3:0]            nib_s;
    seg_t                  dec_seg_s;
    logic [DN-1:0]         lz_s;
    logic                  blank_s;
    logic                  anode_on_s;

    seven_seg_decoder u_decoder (
        .nib (nib_s),
        .seg (dec_seg_s)
    );

    // Scan sequencing and double-buffer commit.
    always_comb begin
        slot_tc_s    = (slot_q == SLOT_LAST);
        frame_end_s  = slot_tc_s && (digit_q == DIGIT_LAST);
        slot_d       = slot_q + SW'(1);
        digit_d      = digit_q;
        shown_d      = shown_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        load_ack_d   = 1'b0;

        if (slot_tc_s) begin
            slot_d  = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
        end else begin
            slot_d  = slot_q + SW'(1);
        end

        if (frame_end_s && pend_valid_q) begin
            shown_d      = pending_q;
            pend_valid_d = 1'b0;
            load_ack_d   = 1'b1;
        end else begin
            shown_d      = shown_q;
        end

        // A load on the commit cycle re-arms pending after the old value moved to shown.
        if (load) begin
            pending_d    = value;
            pend_valid_d = 1'b1;
        end else begin
            pending_d    = pending_q;
        end
    end

    // Digit select, leading-zero detection and anode decode.
    always_comb begin
        logic run_v;
        nib_s      = 4'h0;
        lz_s       = '0;
        run_v      = 1'b1;
        anode_on_s = enable && (slot_q >= GUARD_END);
        anodes_d   = '0;

        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_v   = run_v & (shown_q[4*k +: 4] == 4'h0);
            lz_s[k] = run_v;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib_s       = nib_s | (shown_q[4*k +: 4] & {4{digit_q == DW'(k)}});
            anodes_d[k] = (anode_on_s && (digit_q == DW'(k))) ? ANODE_ON : ~ANODE_ON;
        end

        blank_s    = blank_leading && (digit_q != '0) && lz_s[digit_q];
        segments_d = blank_s ? SEG_BLANK : dec_seg_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q       <= '0;
            digit_q      <= '0;
            shown_q      <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            load_ack_q   <= 1'b0;
            anodes_q     <= {NUM_DIGITS{~ANODE_ON}};
            segments_q   <= SEG_BLANK;
        end else begin
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            shown_q      <= shown_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            load_ack_q   <= load_ack_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
        end
    end

    assign load_ack = load_ack_q;
    assign anodes   = anodes_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Frame-table bench for seven_seg_scanner (4 digits, 4-cycle slots, 1 guard cycle).
module tb_seven_seg_scanner;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SB = 7'b0011111;
    localparam logic [6:0] SX = 7'b0000000;

    typedef struct {
        logic [15:0]     va;
        int              pa;
        logic [15:0]     vb;
        int              pb;
        logic            bl;
        logic [15:0]     en_mask;
        logic [3:0][6:0] seg;
        logic            ack;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic        blank_leading;
    logic        enable;
    logic        load_ack;
    logic [3:0]  anodes;
    logic [6:0]  segments;

    int checks = 0;
    int errors = 0;

    frame_t frames [12];

    seven_seg_scanner #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .GUARD_CYCLES     (1),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .value         (value),
        .load          (load),
        .blank_leading (blank_leading),
        .enable        (enable),
        .load_ack      (load_ack),
        .anodes        (anodes),
        .segments      (segments)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int f);
        logic [3:0] exp_an;
        for (int p = 0; p < 16; p++) begin
            load          = (p == frames[f].pa) || (p == frames[f].pb);
            value         = (p == frames[f].pb) ? frames[f].vb : frames[f].va;
            blank_leading = frames[f].bl;
            enable        = frames[f].en_mask[p];
            @(posedge clk);
            @(negedge clk);
            exp_an = 4'hF;
            if (frames[f].en_mask[p] && ((p % 4) >= 1))
                exp_an[p / 4] = 1'b0;
            chk($sformatf("f%0d p%0d anodes", f, p), 32'(anodes), 32'(exp_an));
            chk($sformatf("f%0d p%0d segments", f, p), 32'(segments), 32'(frames[f].seg[p / 4]));
            chk($sformatf("f%0d p%0d load_ack", f, p), 32'(load_ack),
                32'((p == 15) ? frames[f].ack : 1'b0));
        end
        load = 1'b0;
    endtask

    initial begin
        frames[0]  = '{16'h0000, -1, 16'h0000, -1, 1'b0, 16'hFFFF, {S0, S0, S0, S0}, 1'b0};
        frames[1]  = '{16'h1234,  6, 16'h0000, -1, 1'b0, 16'hFFFF, {S0, S0, S0, S0}, 1'b1};
        frames[2]  = '{16'h0005,  3, 16'h0000, -1, 1'b0, 16'hFFFF, {S1, S2, S3, S4}, 1'b1};
        frames[3]  = '{16'h0000,  2, 16'h0000, -1, 1'b1, 16'hFFFF, {SX, SX, SX, S5}, 1'b1};
        frames[4]  = '{16'hAAAA,  1, 16'hBBBB,  9, 1'b1, 16'hFFFF, {SX, SX, SX, S0}, 1'b1};
        frames[5]  = '{16'h1111,  4, 16'h9999, 15, 1'b1, 16'hFFFF, {SB, SB, SB, SB}, 1'b1};
        frames[6]  = '{16'h0000, -1, 16'h0000, -1, 1'b1, 16'hFFFF, {S1, S1, S1, S1}, 1'b1};
        frames[7]  = '{16'h0042, 15, 16'h0000, -1, 1'b1, 16'hFFFF, {S9, S9, S9, S9}, 1'b0};
        frames[8]  = '{16'h0000, -1, 16'h0000, -1, 1'b1, 16'hFFFF, {S9, S9, S9, S9}, 1'b1};
        frames[9]  = '{16'h0000, -1, 16'h0000, -1, 1'b1, 16'h0000, {SX, SX, S4, S2}, 1'b0};
        frames[10] = '{16'h0000, -1, 16'h0000, -1, 1'b1, 16'hE007, {SX, SX, S4, S2}, 1'b0};
        frames[11] = '{16'h0000, -1, 16'h0000, -1, 1'b0, 16'hFFFF, {S0, S0, S0, S0}, 1'b0};

        reset         = 1'b1;
        value         = 16'h0000;
        load          = 1'b0;
        blank_leading = 1'b0;
        enable        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset anodes", 32'(anodes), 32'hF);
        chk("reset segments", 32'(segments), 32'h0);
        chk("reset load_ack", 32'(load_ack), 32'h0);
        reset = 1'b0;

        for (int f = 0; f <= 10; f++)
            run_frame(f);

        // Reset mid-slot with a pending load outstanding.
        load          = 1'b1;
        value         = 16'h7777;
        blank_leading = 1'b0;
        enable        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset p0 anodes", 32'(anodes), 32'hF);
        chk("pre-reset p0 segments", 32'(segments), 32'(S2));
        load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre-reset p1 anodes", 32'(anodes), 32'hE);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-slot reset anodes", 32'(anodes), 32'hF);
        chk("mid-slot reset segments", 32'(segments), 32'h0);
        chk("mid-slot reset load_ack", 32'(load_ack), 32'h0);
        reset = 1'b0;
        run_frame(11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
